// File: rtl/clint_bridge_pkg.sv
// rtl/clint_bridge_pkg.sv - shared state encoding, CLINT offsets and window decode for clint_bus_bridge
package clint_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

    localparam logic [3:0]  BE_FULL       = 4'hF;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    // Unsigned distance from base: addresses below base wrap to huge values and fail too.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
        logic [31:0] rel;
        rel = addr - base;
        return rel < span;
    endfunction

endpackage

// File: rtl/clint_be_merge.sv
// rtl/clint_be_merge.sv - byte-lane merge of new store data over the old CLINT word
module clint_be_merge
    import clint_bridge_pkg::*;
(
    input  logic [3:0]  be_i,
    input  logic [31:0] new_i,
    input  logic [31:0] old_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                merged_o[8*k +: 8] = new_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/clint_bus_bridge.sv
// rtl/clint_bus_bridge.sv - CPU data-bus to CLINT register port bridge with read-modify-write
// Optional macro CLINT_BRIDGE_ERR_EN: report out-of-window / misaligned accesses via o_rsp_err.
module clint_bus_bridge
    import clint_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h0001_0000
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [15:0] o_clint_offset,
    output logic        o_clint_we,
    output logic [31:0] o_clint_wdata,
    input  logic [31:0] i_clint_rdata
);

    localparam logic [15:0] BASE_LO = BASE_ADDR[15:0];

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [15:0] offset_q, offset_d;
    logic [31:0] clint_wdata_q, clint_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        req_err;
    logic [31:0] merged;

    assign accept  = (state_q == ST_IDLE) && i_req_valid;
    assign req_err = !in_window(i_req_addr, BASE_ADDR, ADDR_SPAN) || (i_req_addr[1:0] != 2'b00);

    clint_be_merge u_merge (
        .be_i     (be_q),
        .new_i    (wdata_q),
        .old_i    (i_clint_rdata),
        .merged_o (merged)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        offset_d      = offset_q;
        clint_wdata_d = clint_wdata_q;
        rdata_d       = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d     = i_req_we;
                    wdata_d  = i_req_wdata;
                    be_d     = i_req_be;
                    offset_d = i_req_addr[15:0] - BASE_LO;
                    rdata_d  = '0;
                    // Errors and empty stores respond at once without touching the CLINT.
                    if (req_err || (i_req_we && (i_req_be == 4'h0))) begin
                        state_d = ST_RSP;
                    end else if (!i_req_we) begin
                        state_d = ST_ISSUE;
                    end else if (i_req_be == BE_FULL) begin
                        clint_wdata_d = i_req_wdata;
                        state_d       = ST_WRITE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (we_q) begin
                    clint_wdata_d = merged;
                    state_d       = ST_WRITE;
                end else begin
                    rdata_d = i_clint_rdata;
                    state_d = ST_RSP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
            offset_q      <= '0;
            clint_wdata_q <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            offset_q      <= offset_d;
            clint_wdata_q <= clint_wdata_d;
            rdata_q       <= rdata_d;
        end
    end

`ifdef CLINT_BRIDGE_ERR_EN
    logic err_q, err_d;

    assign err_d = accept ? req_err : err_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_rsp_err = err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    assign o_req_ready    = (state_q == ST_IDLE);
    assign o_rsp_valid    = (state_q == ST_RSP);
    assign o_clint_we     = (state_q == ST_WRITE);
    assign o_clint_offset = offset_q;
    assign o_clint_wdata  = clint_wdata_q;
    assign o_rsp_rdata    = rdata_q;

endmodule
